// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared types and constants for the Mario sprite controller
package mario_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WALK_A    = 3'd1,
    WALK_B    = 3'd2,
    JUMP_UP   = 3'd3,
    JUMP_DOWN = 3'd4
  } state_t;

  localparam logic [1:0] FRM_STAND = 2'd0;
  localparam logic [1:0] FRM_MOVE  = 2'd1;
  localparam logic [1:0] FRM_JUMP  = 2'd2;

  localparam int SPRITE_W = 32;

endpackage

// File: rtl/mario_pixel_window.sv
// rtl/mario_pixel_window.sv - scan coordinate to sprite address, mirroring and colour register
module mario_pixel_window
  import mario_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] mario_x,
  input  logic [9:0] mario_y,
  input  logic       facing_left,
  input  logic [1:0] mem_pixel,
  output logic [9:0] mem_horz,
  output logic [9:0] mem_vert,
  output logic [1:0] draw_mario
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_box;
  logic [4:0]  dx;
  logic [4:0]  dy;
  logic [1:0]  pix_clean;

  // Right/bottom edges are one bit wider so a sprite near 1023 cannot wrap.
  assign x_end  = {1'b0, mario_x} + 11'(SPRITE_W);
  assign y_end  = {1'b0, mario_y} + 11'(SPRITE_W);
  assign in_box = (pix_x >= mario_x) && ({1'b0, pix_x} < x_end) &&
                  (pix_y >= mario_y) && ({1'b0, pix_y} < y_end);

  // Only the low five bits of the offset matter inside the 32-px box.
  assign dx = pix_x[4:0] - mario_x[4:0];
  assign dy = pix_y[4:0] - mario_y[4:0];

  assign mem_horz = in_box ? {5'd0, (facing_left ? (5'd31 - dx) : dx)} : 10'd0;
  assign mem_vert = in_box ? {5'd0, dy} : 10'd0;

  // An unknown memory bit fails the if-test and resolves to 0.
  always_comb begin
    pix_clean = 2'b00;
    if (mem_pixel[1]) pix_clean[1] = 1'b1;
    if (mem_pixel[0]) pix_clean[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      draw_mario <= 2'd0;
    end else if (in_box) begin
      draw_mario <= pix_clean;
    end else begin
      draw_mario <= 2'd0;
    end
  end

endmodule

// File: rtl/mario_sprite_ctrl.sv
// rtl/mario_sprite_ctrl.sv - Mario position, walk/jump state machine and sprite frame select
module mario_sprite_ctrl
  import mario_pkg::*;
#(
  parameter int X_START    = 64,
  parameter int GROUND_Y   = 400,
  parameter int X_MAX      = 640,
  parameter int STEP       = 2,
  parameter int JUMP_STEP  = 4,
  parameter int JUMP_TICKS = 8,
  parameter int ANIM_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] mem_horz,
  output logic [9:0] mem_vert,
  output logic [1:0] frame_sel,
  input  logic [1:0] mem_pixel,
  output logic [1:0] draw_mario,
  output logic [9:0] mario_x,
  output logic [9:0] mario_y
);

  localparam logic signed [10:0] X_LIM     = 11'(X_MAX - SPRITE_W);
  localparam logic signed [10:0] STEP_S    = 11'(STEP);
  localparam logic [9:0]         JSTEP     = 10'(JUMP_STEP);
  localparam logic [7:0]         ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [7:0]         JUMP_LAST = 8'(JUMP_TICKS - 1);

  state_t            state;
  logic              facing_left;
  logic [7:0]        anim_cnt;
  logic [7:0]        jump_cnt;
  logic              move_r;
  logic              move_l;
  logic              one_dir;
  logic signed [10:0] x_ext;
  logic signed [10:0] x_moved;
  logic [9:0]        x_next;

  assign move_r  = btn_right & ~btn_left;
  assign move_l  = btn_left & ~btn_right;
  assign one_dir = btn_left ^ btn_right;

  // Signed 11-bit arithmetic lets a step left of 0 go negative and be clamped.
  always_comb begin
    x_ext   = signed'({1'b0, mario_x});
    x_moved = x_ext;
    if (move_r) begin
      x_moved = x_ext + STEP_S;
    end else if (move_l) begin
      x_moved = x_ext - STEP_S;
    end
    if (x_moved < 11'sd0) begin
      x_next = 10'd0;
    end else if (x_moved > X_LIM) begin
      x_next = X_LIM[9:0];
    end else begin
      x_next = x_moved[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mario_x     <= 10'(X_START);
      mario_y     <= 10'(GROUND_Y);
      facing_left <= 1'b0;
      state       <= IDLE;
      anim_cnt    <= 8'd0;
      jump_cnt    <= 8'd0;
      frame_sel   <= FRM_STAND;
    end else if (frame_tick) begin
      mario_x <= x_next;
      if (move_r) begin
        facing_left <= 1'b0;
      end else if (move_l) begin
        facing_left <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (btn_jump) begin
            state     <= JUMP_UP;
            jump_cnt  <= 8'd0;
            frame_sel <= FRM_JUMP;
          end else if (one_dir) begin
            state     <= WALK_A;
            anim_cnt  <= 8'd0;
            frame_sel <= FRM_STAND;
          end
        end

        WALK_A, WALK_B: begin
          if (btn_jump) begin
            state     <= JUMP_UP;
            jump_cnt  <= 8'd0;
            frame_sel <= FRM_JUMP;
          end else if (!one_dir) begin
            state     <= IDLE;
            frame_sel <= FRM_STAND;
          end else if (anim_cnt == ANIM_LAST) begin
            anim_cnt <= 8'd0;
            if (state == WALK_A) begin
              state     <= WALK_B;
              frame_sel <= FRM_MOVE;
            end else begin
              state     <= WALK_A;
              frame_sel <= FRM_STAND;
            end
          end else begin
            anim_cnt <= anim_cnt + 8'd1;
          end
        end

        JUMP_UP: begin
          mario_y <= mario_y - JSTEP;
          if (jump_cnt == JUMP_LAST) begin
            state    <= JUMP_DOWN;
            jump_cnt <= 8'd0;
          end else begin
            jump_cnt <= jump_cnt + 8'd1;
          end
        end

        JUMP_DOWN: begin
          if (jump_cnt == JUMP_LAST) begin
            // The descent mirrors the ascent, so this lands exactly on the ground.
            mario_y   <= 10'(GROUND_Y);
            state     <= IDLE;
            jump_cnt  <= 8'd0;
            frame_sel <= FRM_STAND;
          end else begin
            mario_y  <= mario_y + JSTEP;
            jump_cnt <= jump_cnt + 8'd1;
          end
        end

        default: begin
          state     <= IDLE;
          frame_sel <= FRM_STAND;
        end
      endcase
    end
  end

  mario_pixel_window u_window (
    .clk         (clk),
    .rst         (rst),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .mario_x     (mario_x),
    .mario_y     (mario_y),
    .facing_left (facing_left),
    .mem_pixel   (mem_pixel),
    .mem_horz    (mem_horz),
    .mem_vert    (mem_vert),
    .draw_mario  (draw_mario)
  );

endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// tb/tb_mario_sprite_ctrl.sv - directed and randomized checks of mario_sprite_ctrl against a reference model
module tb_mario_sprite_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [9:0] mem_horz;
  logic [9:0] mem_vert;
  logic [1:0] frame_sel;
  logic [1:0] mem_pixel;
  logic [1:0] draw_mario;
  logic [9:0] mario_x;
  logic [9:0] mario_y;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: mode 0 = standing, 1 = walking, 2 = airborne
  int m_x, m_y, m_mode, m_walk_age, m_air_age;
  bit m_left;

  always #5 clk = ~clk;

  mario_sprite_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .mem_horz   (mem_horz),
    .mem_vert   (mem_vert),
    .frame_sel  (frame_sel),
    .mem_pixel  (mem_pixel),
    .draw_mario (draw_mario),
    .mario_x    (mario_x),
    .mario_y    (mario_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_frame();
    if (m_mode == 2) return 2;
    if (m_mode == 1) return (m_walk_age / 8) % 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_x = 64; m_y = 400; m_mode = 0; m_walk_age = 0; m_air_age = 0; m_left = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int nx;
    nx = m_x + ((r && !l) ? 2 : 0) - ((l && !r) ? 2 : 0);
    if (nx < 0) nx = 0;
    if (nx > 608) nx = 608;
    m_x = nx;
    if (r && !l) m_left = 0;
    if (l && !r) m_left = 1;
    if (m_mode == 2) begin
      m_air_age++;
      if (m_air_age >= 16) begin
        m_mode = 0;
        m_y = 400;
      end else begin
        m_y = 400 - 4 * ((m_air_age <= 8) ? m_air_age : 16 - m_air_age);
      end
    end else if (j) begin
      m_mode = 2;
      m_air_age = 0;
    end else if (l ^ r) begin
      if (m_mode == 0) m_walk_age = 0;
      else m_walk_age++;
      m_mode = 1;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic tick(input bit l, input bit r, input bit j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(l, r, j);
    chk("mario_x", 32'(mario_x), 32'(m_x));
    chk("mario_y", 32'(mario_y), 32'(m_y));
    chk("frame_sel", 32'(frame_sel), 32'(exp_frame()));
  endtask

  task automatic probe(input int px, input int py, input int mp);
    bit inb;
    int eh, ev;
    @(negedge clk);
    pix_x = 10'(px); pix_y = 10'(py); mem_pixel = 2'(mp);
    inb = (px >= m_x) && (px < m_x + 32) && (py >= m_y) && (py < m_y + 32);
    eh = inb ? (m_left ? 31 - (px - m_x) : px - m_x) : 0;
    ev = inb ? py - m_y : 0;
    #1;
    chk("mem_horz", 32'(mem_horz), 32'(eh));
    chk("mem_vert", 32'(mem_vert), 32'(ev));
    @(negedge clk);
    chk("draw_mario", 32'(draw_mario), inb ? 32'(mp) : 32'd0);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0; mem_pixel = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_x", 32'(mario_x), 32'd64);
    chk("reset_y", 32'(mario_y), 32'd400);
    chk("reset_frame_sel", 32'(frame_sel), 32'd0);
    chk("reset_draw", 32'(draw_mario), 32'd0);

    probe(64, 400, 3);
    probe(96, 400, 3);
    probe(95, 431, 1);

    tick(1, 0, 0);
    chk("left_x", 32'(mario_x), 32'd62);
    probe(62, 400, 2);
    chk("mirror_left_edge", 32'(mem_horz), 32'd31);
    probe(93, 431, 1);
    chk("mirror_right_edge", 32'(mem_horz), 32'd0);
    chk("bottom_row", 32'(mem_vert), 32'd31);
    tick(0, 0, 0);

    tick(0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1);
      if (i == 7) chk("jump_apex", 32'(mario_y), 32'd368);
      if (i < 15) chk("jump_frame", 32'(frame_sel), 32'd2);
    end
    chk("landed_y", 32'(mario_y), 32'd400);
    chk("landed_frame", 32'(frame_sel), 32'd0);
    tick(0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      tick(0, 1, 0);
      chk("walk_frame", 32'(frame_sel), (i < 8) ? 32'd0 : 32'd1);
    end
    tick(0, 0, 0);
    chk("release_frame", 32'(frame_sel), 32'd0);
    tick(1, 1, 0);
    tick(1, 1, 0);

    for (int i = 0; i < 400 && m_x < 606; i++) tick(0, 1, 0);
    chk("reach_606", 32'(mario_x), 32'd606);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0);
      chk("clamp_right", 32'(mario_x), 32'd608);
    end
    probe(608, 400, 3);
    probe(639, 431, 2);
    for (int i = 0; i < 400 && m_x > 0; i++) tick(1, 0, 0);
    tick(1, 0, 0);
    chk("clamp_left", 32'(mario_x), 32'd0);
    probe(0, 400, 1);
    tick(0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      bit l, r, j;
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 9) == 0);
      tick(l, r, j);
      for (int k = 0; k < 2; k++)
        probe(m_x + $urandom_range(0, 47) - 8, m_y + $urandom_range(0, 47) - 8, $urandom_range(0, 3));
    end

    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 1, 0);
    @(negedge clk);
    pix_x = 10'(m_x); pix_y = 10'(m_y); mem_pixel = 2'd2;
    rst = 1'b1; frame_tick = 1'b1; btn_right = 1'b1;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; btn_right = 1'b0;
    model_reset();
    chk("rst_mid_jump_y", 32'(mario_y), 32'd400);
    chk("rst_mid_jump_x", 32'(mario_x), 32'd64);
    chk("rst_mid_jump_frame", 32'(frame_sel), 32'd0);
    chk("rst_mid_jump_draw", 32'(draw_mario), 32'd0);
    tick(0, 0, 0);
    chk("rst_idle_hold_y", 32'(mario_y), 32'd400);
    probe(64, 400, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mario_sprite_ctrl.md
Name: mario_sprite_ctrl

Overview:
Sequences Mario's 32x32 2-bit-colour sprite memories: it tracks Mario's screen position, runs the walk/jump animation state machine, and selects which sprite frame is shown. On every pixel it converts the VGA scan coordinate into a local sprite address and returns the colour index, with horizontal mirroring when Mario faces left. It sits between the VGA sync counter, the input buttons and the sprite memories, feeding the colour mux.

Parameters:
X_START, 64, reset x position of the sprite's top-left corner (px)
GROUND_Y, 400, reset/ground y position of the sprite's top-left corner (px)
X_MAX, 640, right screen bound; mario_x is clamped to 0..X_MAX-SPRITE_W
STEP, 2, horizontal px moved per frame_tick
JUMP_STEP, 4, vertical px moved per frame_tick while jumping
JUMP_TICKS, 8, frame_ticks spent rising; the same count is spent falling
ANIM_DIV, 8, frame_ticks per walk-frame toggle
SPRITE_W, 32, sprite edge length (px); fixed at 32

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at the start of vertical blank
btn_left  in  1  move-left request, level
btn_right  in  1  move-right request, level
btn_jump  in  1  jump request, level
pix_x  in  10  current scan column
pix_y  in  10  current scan row
mem_horz  out  10  local column address to the sprite memories (0..31)
mem_vert  out  10  local row address to the sprite memories (0..31)
frame_sel  out  2  sprite memory select: 0 = stand, 1 = move, 2 = jump
mem_pixel  in  2  colour index returned combinationally by the selected memory
draw_mario  out  2  registered colour index; 0 = transparent
mario_x  out  10  current x position
mario_y  out  10  current y position

Behaviour:
- Reset values: mario_x=X_START, mario_y=GROUND_Y, facing right, state IDLE, anim_cnt=0, jump_cnt=0, draw_mario=0, frame_sel=0.
- Reset takes priority over a coincident frame_tick.
- Reset mid-jump forces mario_y back to GROUND_Y on the next clock.
- Position, facing and state update only on frame_tick, so they are stable for a whole scanned frame.
- Horizontal movement on each tick:
  - btn_right only: x += STEP, facing right.
  - btn_left only: x -= STEP, facing left.
  - Both or neither: x unchanged, facing unchanged.
  - Clamp to 0..X_MAX-SPRITE_W. Compute in 11-bit signed so there is no wrap: 0 minus STEP gives 0.
- State machine, evaluated on frame_tick:
  - IDLE: btn_jump -> JUMP_UP with jump_cnt=0. Otherwise, exactly one direction held -> WALK_A with anim_cnt=0.
  - WALK_A / WALK_B: btn_jump -> JUMP_UP. No direction or both held -> IDLE. Otherwise anim_cnt++; when anim_cnt reaches ANIM_DIV-1, toggle WALK_A<->WALK_B and clear anim_cnt.
  - JUMP_UP: y -= JUMP_STEP, jump_cnt++. After the JUMP_TICKS-th tick -> JUMP_DOWN and clear jump_cnt.
  - JUMP_DOWN: y += JUMP_STEP. After JUMP_TICKS ticks, y equals GROUND_Y exactly -> IDLE.
  - btn_jump is ignored in both JUMP states. Horizontal movement stays active during a jump.
- frame_sel by state: IDLE=0, WALK_A=0, WALK_B=1, JUMP_UP/JUMP_DOWN=2.
- Pixel path:
  - dx = pix_x - mario_x, dy = pix_y - mario_y.
  - in_box = (pix_x >= mario_x) && (pix_x < mario_x+32) && (pix_y >= mario_y) && (pix_y < mario_y+32).
  - mem_horz = in_box ? (facing_left ? 31-dx : dx) : 0. mem_vert = in_box ? dy : 0.
  - Addresses are always within 0..31, so the memory never reads out of range.
  - draw_mario <= in_box ? mem_pixel : 0, giving 1-cycle latency from pix_x/pix_y.
  - An X value on mem_pixel while in_box is registered as 0.

Decomposition:
- Package mario_pkg holds:
  - state_t enum {IDLE, WALK_A, WALK_B, JUMP_UP, JUMP_DOWN};
  - frame_sel constants FRM_STAND=0, FRM_MOVE=1, FRM_JUMP=2;
  - SPRITE_W.
- One sub-module, mario_pixel_window: the in_box test, the subtract/mirror address generation and the draw_mario register.
- The FSM and position logic stay in the top.

Test Plan:
- After reset, pix=(64,400), mem_pixel=3 -> mem_horz=0, mem_vert=0, draw_mario=3 one cycle later. pix=(96,400) -> draw_mario=0.
- Hold btn_left for 1 tick, then pix=(62,400) with mem_pixel driven -> mario_x=62, mem_horz=31. pix=(93,431) -> mem_horz=0, mem_vert=31.
- Force mario_x=606, hold btn_right for 3 ticks -> x=608, 608, 608. From x=1, hold btn_left for 1 tick -> x=0.
- Pulse btn_jump in IDLE -> 8 ticks in JUMP_UP reaching y=368, then 8 ticks in JUMP_DOWN back to y=400, then IDLE. frame_sel=2 throughout. btn_jump held during the jump is ignored.
- Hold btn_right for 16 ticks -> frame_sel sequence 0x8, 1x8 (WALK_A then WALK_B). Release -> IDLE, frame_sel=0. Both buttons held -> x unchanged, IDLE.
- Assert rst during tick 5 of JUMP_UP -> next cycle y=400, x=64, state IDLE, draw_mario=0. A coincident frame_tick is ignored.
